// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the dm_bus data memory.
//   - access-size encodings carried on req_size
//   - response FSM state type
//   - byte-lane mapping between byte address and bit position in a word
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Wide enough for LATENCY-1 up to 7.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } stateT;

  // Lane 0 is bits 7:0 of the stored word. In big-endian mode byte 0 of a
  // word sits in bits 31:24, so the address offset is mirrored.
  function automatic logic [1:0] laneMap(input logic [1:0] addrLo, input bit bigEndian);
    return bigEndian ? (addrLo ^ 2'b11) : addrLo;
  endfunction

endpackage

// File: rtl/dm_bus_if.sv
// dm_bus_if: request/response bundle between the datapath and dm_bus.
//   master: drives req_valid/req_we/req_size/req_signed/req_addr/req_wdata,
//           observes req_ready and the rsp_* outputs.
//   slave : the memory side, the mirror image of master.
// One outstanding access; rsp_valid is a single-cycle completion pulse and
// rsp_err/rsp_rdata are only meaningful while it is high.
interface dm_bus_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dm_lane_align.sv
// dm_lane_align: purely combinational lane steering for dm_bus.
//   addrLo    in   low two bits of the byte address
//   size      in   access size (SZ_BYTE/SZ_HALF/SZ_WORD, 11 illegal)
//   signExt   in   sign-extend narrow loads when 1
//   storeData in   store data, narrow stores use the low bits
//   memWord   in   word currently stored at the addressed index
//   byteEn    out  per-lane write enables, all zero on error
//   laneData  out  store data replicated onto the selected lanes
//   loadData  out  extracted and extended load value, zero on error
//   misalign  out  access error: misaligned address or illegal size
module dm_lane_align
  import dm_pkg::*;
#(
  parameter int BIG_ENDIAN = 1
) (
  input  logic [1:0]  addrLo,
  input  logic [1:0]  size,
  input  logic        signExt,
  input  logic [31:0] storeData,
  input  logic [31:0] memWord,
  output logic [3:0]  byteEn,
  output logic [31:0] laneData,
  output logic [31:0] loadData,
  output logic        misalign
);

  logic [1:0]  byteLane;
  logic [1:0]  halfLane;
  logic        halfHi;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;

  always_comb begin
    byteLane = laneMap(addrLo, BIG_ENDIAN != 0);
    // Halfword pairs are {1,0} and {3,2}; the mapped lane of the first byte
    // of the pair tells which half of the word is addressed.
    halfLane = laneMap({addrLo[1], 1'b0}, BIG_ENDIAN != 0);
    halfHi   = halfLane[1];
    loadByte = memWord[8*byteLane +: 8];
    loadHalf = halfHi ? memWord[31:16] : memWord[15:0];

    misalign = 1'b0;
    byteEn   = 4'b0000;
    laneData = storeData;
    loadData = '0;

    case (size)
      SZ_BYTE: begin
        byteEn   = 4'b0001 << byteLane;
        laneData = {4{storeData[7:0]}};
        loadData = {{24{signExt & loadByte[7]}}, loadByte};
      end
      SZ_HALF: begin
        misalign = addrLo[0];
        byteEn   = halfHi ? 4'b1100 : 4'b0011;
        laneData = {2{storeData[15:0]}};
        loadData = {{16{signExt & loadHalf[15]}}, loadHalf};
      end
      SZ_WORD: begin
        misalign = |addrLo;
        byteEn   = 4'b1111;
        laneData = storeData;
        loadData = memWord;
      end
      default: misalign = 1'b1;
    endcase

    if (misalign) begin
      byteEn   = 4'b0000;
      loadData = '0;
    end
  end

endmodule

// File: rtl/dm_bus.sv
// dm_bus: byte/halfword/word data memory with a valid/ready request port,
// one outstanding access and a fixed response latency.
//   clk  in   clock
//   rst  in   synchronous active-high reset (memory contents are kept)
//   bus  slave modport of dm_bus_if (request in, response out)
//
// Stores commit at the acceptance edge; loads are extracted at the
// acceptance edge and held until the response pulse.
//
// state | meaning
// IDLE  | req_ready high, waiting for req_valid
// WAIT  | access done, counting down the remaining latency
// RESP  | rsp_valid high for this single cycle
module dm_bus
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 12,
  parameter int LATENCY     = 1,
  parameter int BIG_ENDIAN  = 1
) (
  input logic     clk,
  input logic     rst,
  dm_bus_if.slave bus
);

  localparam int IDX_W = ADDR_W - 2;

  logic [31:0] mem [DEPTH_WORDS];

  stateT            state;
  logic [CNT_W-1:0] cnt;
  logic             reqReady;
  logic             rspValid;
  logic [31:0]      rspRdata;
  logic             rspErr;
  logic [31:0]      holdData;
  logic             holdErr;

  logic [IDX_W-1:0] wordIdx;
  logic [31:0]      memWord;
  logic [3:0]       byteEn;
  logic [31:0]      laneData;
  logic [31:0]      loadData;
  logic             misalign;
  logic             accept;
  logic             memWrEn;
  logic [31:0]      respData;

  assign wordIdx  = bus.req_addr[ADDR_W-1:2];
  assign memWord  = mem[wordIdx];
  assign accept   = bus.req_valid & reqReady;
  // Reset has priority over a request presented in the same cycle.
  assign memWrEn  = accept & bus.req_we & ~rst;
  // Stores and errored accesses complete with zero data.
  assign respData = (bus.req_we | misalign) ? 32'h0 : loadData;

  dm_lane_align #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) uLaneAlign (
    .addrLo   (bus.req_addr[1:0]),
    .size     (bus.req_size),
    .signExt  (bus.req_signed),
    .storeData(bus.req_wdata),
    .memWord  (memWord),
    .byteEn   (byteEn),
    .laneData (laneData),
    .loadData (loadData),
    .misalign (misalign)
  );

  always_ff @(posedge clk) begin
    if (memWrEn) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[wordIdx][8*i +: 8] <= laneData[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      reqReady <= 1'b1;
      rspValid <= 1'b0;
      rspRdata <= '0;
      rspErr   <= 1'b0;
      holdData <= '0;
      holdErr  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            reqReady <= 1'b0;
            holdData <= respData;
            holdErr  <= misalign;
            if (LATENCY == 1) begin
              state    <= RESP;
              rspValid <= 1'b1;
              rspRdata <= respData;
              rspErr   <= misalign;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          // Leaving at cnt==1 puts rsp_valid in the cycle after edge
          // t+LATENCY-1 for a request accepted at edge t.
          if (cnt == CNT_W'(1)) begin
            state    <= RESP;
            rspValid <= 1'b1;
            rspRdata <= holdData;
            rspErr   <= holdErr;
          end
        end
        RESP: begin
          state    <= IDLE;
          reqReady <= 1'b1;
          rspValid <= 1'b0;
          rspRdata <= '0;
          rspErr   <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          reqReady <= 1'b1;
          rspValid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = reqReady;
  assign bus.rsp_valid = rspValid;
  assign bus.rsp_rdata = rspRdata;
  assign bus.rsp_err   = rspErr;

endmodule
